// File: rtl/hit_dump_buffer.sv
// hit_dump_buffer: stages TDC FIFO bytes into 32-bit words, then on a dump
// request writes a header plus the packed words into the IPbus RAM and runs
// a two-phase ready/acknowledge handshake with the PC before re-arming.
module hit_dump_buffer #(
    parameter int MAX_WORDS = 255
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        dump_req,
    output logic        dump_done,
    output logic [31:0] ram_data,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic        handshake_fpga,
    input  logic        handshake_pc,
    output logic        overflow,
    output logic [9:0]  fill_bytes
);

    localparam logic [9:0] CAP_BYTES = 10'(4 * MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        HS_UP,
        HS_DOWN,
        DONE
    } state_t;

    state_t      state_reg,    state_next;
    logic        armed_reg,    armed_next;
    logic [9:0]  fill_reg,     fill_next;
    logic        ovf_reg,      ovf_next;
    logic [7:0]  seq_reg,      seq_next;
    logic [9:0]  nbytes_reg,   nbytes_next;
    logic [7:0]  nwords_reg,   nwords_next;
    logic [7:0]  word_reg,     word_next;
    logic        we_reg,       we_next;
    logic [7:0]  addr_reg,     addr_next;
    logic [31:0] data_reg,     data_next;
    logic        hs_reg,       hs_next;
    logic        pc_meta_reg;
    logic        pc_sync_reg;

    // Buffer port control, produced by the FSM
    logic        wr_store;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_word;
    logic [31:0] rd_masked;
    logic [8:0]  word_inc;

    assign word_inc = {1'b0, word_reg} + 9'd1;

    // One byte-wide RAM per lane: a byte lands in lane fill[1:0] of word
    // fill[9:2]. Lanes past the captured length are zeroed on the way out so
    // stale bytes from an earlier trigger never reach the PC.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [MAX_WORDS];
            logic [7:0] q_reg;

            // Lane write from capture, registered read for the dump pipeline
            always_ff @(posedge SYSCLK) begin
                if (wr_store && (fill_reg[1:0] == 2'(gi))) begin
                    mem[fill_reg[9:2]] <= wr_data;
                end
                if (rd_en) begin
                    q_reg <= mem[rd_addr];
                end
            end

            assign rd_word[gi*8 +: 8]   = q_reg;
            assign rd_masked[gi*8 +: 8] = ({word_reg, 2'(gi)} < nbytes_reg) ?
                                          q_reg : 8'h00;
        end
    endgenerate

    // Two-flop synchroniser for the PC acknowledge
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            pc_meta_reg <= 1'b0;
            pc_sync_reg <= 1'b0;
        end else begin
            pc_meta_reg <= handshake_pc;
            pc_sync_reg <= pc_meta_reg;
        end
    end

    // State and datapath registers
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_reg  <= IDLE;
            armed_reg  <= 1'b0;
            fill_reg   <= 10'd0;
            ovf_reg    <= 1'b0;
            seq_reg    <= 8'd0;
            nbytes_reg <= 10'd0;
            nwords_reg <= 8'd0;
            word_reg   <= 8'd0;
            we_reg     <= 1'b0;
            addr_reg   <= 8'd0;
            data_reg   <= 32'd0;
            hs_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            armed_reg  <= armed_next;
            fill_reg   <= fill_next;
            ovf_reg    <= ovf_next;
            seq_reg    <= seq_next;
            nbytes_reg <= nbytes_next;
            nwords_reg <= nwords_next;
            word_reg   <= word_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            hs_reg     <= hs_next;
        end
    end

    // Next-state, capture and RAM-write decode
    always_comb begin
        state_next  = state_reg;
        armed_next  = armed_reg;
        fill_next   = fill_reg;
        ovf_next    = ovf_reg;
        seq_next    = seq_reg;
        nbytes_next = nbytes_reg;
        nwords_next = nwords_reg;
        word_next   = word_reg;
        we_next     = 1'b0;
        addr_next   = 8'd0;
        data_next   = 32'd0;
        hs_next     = 1'b0;
        dump_done   = 1'b0;
        wr_store    = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = 8'd0;

        // A low request re-arms; a request still high after DONE cannot retrigger
        if (!dump_req) begin
            armed_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (wr_en) begin
                    if (fill_reg == CAP_BYTES) begin
                        ovf_next = 1'b1;
                    end else begin
                        wr_store  = 1'b1;
                        fill_next = fill_reg + 10'd1;
                    end
                end
                // Latch the length including any byte captured this same cycle
                if (dump_req && armed_reg) begin
                    state_next  = HEADER;
                    armed_next  = 1'b0;
                    nbytes_next = fill_next;
                    nwords_next = 8'((fill_next + 10'd3) >> 2);
                    word_next   = 8'd0;
                end
            end

            HEADER: begin
                we_next    = 1'b1;
                addr_next  = 8'd0;
                data_next  = {ovf_reg, 7'b0, seq_reg, 6'b0, nbytes_reg};
                // Prefetch word 0 so it is ready for the first DATA cycle
                rd_en      = 1'b1;
                rd_addr    = 8'd0;
                state_next = (nwords_reg != 8'd0) ? DATA : HS_UP;
            end

            DATA: begin
                we_next   = 1'b1;
                addr_next = word_inc[7:0];
                data_next = rd_masked;
                word_next = word_inc[7:0];
                if (word_inc < {1'b0, nwords_reg}) begin
                    rd_en   = 1'b1;
                    rd_addr = word_inc[7:0];
                end else begin
                    state_next = HS_UP;
                end
            end

            HS_UP: begin
                // Ready is raised one cycle after entry, dropped on the ack edge
                if (pc_sync_reg) begin
                    state_next = HS_DOWN;
                end else begin
                    hs_next = 1'b1;
                end
            end

            HS_DOWN: begin
                if (!pc_sync_reg) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                dump_done  = 1'b1;
                fill_next  = 10'd0;
                ovf_next   = 1'b0;
                seq_next   = seq_reg + 8'd1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ram_we         = we_reg;
    assign ram_addr       = addr_reg;
    assign ram_data       = data_reg;
    assign handshake_fpga = hs_reg;
    assign overflow       = ovf_reg;
    assign fill_bytes     = fill_reg;

endmodule

// File: tb/tb_hit_dump_buffer.sv
// Directed bench for hit_dump_buffer: captures, dumps, handshakes, resets.
module tb_hit_dump_buffer;

    logic        SYSCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        dump_req = 1'b0;
    logic        dump_done;
    logic [31:0] ram_data;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic        handshake_fpga;
    logic        handshake_pc = 1'b0;
    logic        overflow;
    logic [9:0]  fill_bytes;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Write monitor state
    logic        mon_clr = 1'b0;
    logic [31:0] mem_img [256];
    int          we_count, we_first, we_last, hs_rise, done_count;
    bit          addr_ok, hs_prev;

    hit_dump_buffer #(.MAX_WORDS(255)) dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .wr_en(wr_en), .wr_data(wr_data),
        .dump_req(dump_req), .dump_done(dump_done), .ram_data(ram_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .handshake_fpga(handshake_fpga),
        .handshake_pc(handshake_pc), .overflow(overflow), .fill_bytes(fill_bytes)
    );

    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK) cyc <= cyc + 1;

    // Record RAM writes and handshake activity on the falling edge
    always @(negedge SYSCLK) begin
        if (mon_clr) begin
            for (int i = 0; i < 256; i++) mem_img[i] = 32'hDEADBEEF;
            we_count = 0; we_first = -1; we_last = -1; hs_rise = -1;
            done_count = 0; addr_ok = 1'b1; hs_prev = 1'b0;
        end else begin
            if (ram_we === 1'b1) begin
                if (ram_addr !== 8'(we_count)) addr_ok = 1'b0;
                mem_img[ram_addr] = ram_data;
                if (we_first < 0) we_first = cyc;
                we_last = cyc;
                we_count++;
            end
            if (handshake_fpga === 1'b1 && !hs_prev && hs_rise < 0) hs_rise = cyc;
            hs_prev = (handshake_fpga === 1'b1);
            if (dump_done === 1'b1) done_count++;
        end
    end

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; wr_en = 1'b0; dump_req = 1'b0; handshake_pc = 1'b0;
        mon_clr = 1'b1;
        tick(); tick();
        RESET = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic write_bytes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; wr_data = 8'(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Full dump: request, optional byte with the request, optional wr_en
    // during DATA, wait for ready, PC ack both phases, check pulse timing.
    task automatic do_dump(input int t0_byte, input int data_wr, input bit keep_req,
                           output int t0, output logic [9:0] fill_at_hs,
                           output logic ovf_at_hs);
        int guard;
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
        dump_req = 1'b1; t0 = cyc;
        if (t0_byte >= 0) begin wr_en = 1'b1; wr_data = 8'(t0_byte); end
        tick(); wr_en = 1'b0;
        tick();
        for (int i = 0; i < data_wr; i++) begin wr_en = 1'b1; wr_data = 8'hEE; tick(); end
        wr_en = 1'b0;
        guard = 0;
        while (handshake_fpga !== 1'b1 && guard < 600) begin tick(); guard++; end
        fill_at_hs = fill_bytes; ovf_at_hs = overflow;
        total_cnt++;
        if (handshake_fpga !== 1'b1) begin
            $display("FAIL hs_timeout: handshake_fpga=%b required 1", handshake_fpga);
            dump_req = 1'b0;
            return;
        end else pass_cnt++;
        handshake_pc = 1'b1;
        tick(); tick();
        total_cnt++;
        if (handshake_fpga !== 1'b1) $display("FAIL hs_hold: handshake_fpga=%b required 1 two cycles after ack", handshake_fpga);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (handshake_fpga !== 1'b0) $display("FAIL hs_fall: handshake_fpga=%b required 0 three cycles after ack", handshake_fpga);
        else pass_cnt++;
        handshake_pc = 1'b0;
        tick(); tick();
        total_cnt++;
        if (dump_done !== 1'b0) $display("FAIL done_early: dump_done=%b required 0", dump_done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dump_done !== 1'b1) $display("FAIL done_pulse: dump_done=%b required 1", dump_done);
        else pass_cnt++;
        if (!keep_req) dump_req = 1'b0;
        tick();
        total_cnt++;
        if ({dump_done, fill_bytes, overflow} !== 12'd0)
            $display("FAIL done_clear: done=%b fill=%0d ovf=%b required 0/0/0", dump_done, fill_bytes, overflow);
        else pass_cnt++;
        $display("dump t0=%0d we=%0d hdr=%08h done=%0d", t0, we_count, mem_img[0], done_count);
    endtask

    task automatic test_reset();
        RESET = 1'b1; wr_en = 1'b1; wr_data = 8'h5A; dump_req = 1'b1;
        tick(); tick();
        total_cnt++;
        if ({ram_we, ram_addr, ram_data, handshake_fpga, dump_done, overflow, fill_bytes} !== 54'd0)
            $display("FAIL reset_outputs: we=%b addr=%h data=%h hs=%b done=%b ovf=%b fill=%0d required all 0",
                     ram_we, ram_addr, ram_data, handshake_fpga, dump_done, overflow, fill_bytes);
        else pass_cnt++;
        wr_en = 1'b0; dump_req = 1'b0;
        do_reset();
        $display("reset checked");
    endtask

    task automatic test_basic();
        int t0; logic [9:0] f; logic o;
        do_reset();
        write_bytes(1, 8'h11); write_bytes(1, 8'h22); write_bytes(1, 8'h33);
        total_cnt++;
        if (fill_bytes !== 10'd3) $display("FAIL basic_fill: fill=%0d required 3", fill_bytes);
        else pass_cnt++;
        do_dump(-1, 0, 1'b0, t0, f, o);
        total_cnt++;
        if (mem_img[0] !== 32'h00000003) $display("FAIL basic_hdr: got %08h required 00000003", mem_img[0]);
        else pass_cnt++;
        total_cnt++;
        if (mem_img[1] !== 32'h00332211) $display("FAIL basic_word: got %08h required 00332211", mem_img[1]);
        else pass_cnt++;
        total_cnt++;
        if (we_count !== 2 || we_first !== t0 + 2 || we_last !== t0 + 3 || !addr_ok)
            $display("FAIL basic_we: count=%0d first=%0d last=%0d addr_ok=%b required 2/%0d/%0d/1",
                     we_count, we_first, we_last, addr_ok, t0 + 2, t0 + 3);
        else pass_cnt++;
        total_cnt++;
        if (hs_rise !== t0 + 4) $display("FAIL basic_hs_rise: cycle %0d required %0d", hs_rise, t0 + 4);
        else pass_cnt++;
        total_cnt++;
        if (done_count !== 1) $display("FAIL basic_done_count: %0d required 1", done_count);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int t0; logic [9:0] f; logic o;
        do_reset();
        for (int i = 0; i < 1021; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); tick();
        end
        wr_en = 1'b0;
        total_cnt++;
        if (overflow !== 1'b1 || fill_bytes !== 10'd1020)
            $display("FAIL ovf_set: ovf=%b fill=%0d required 1/1020", overflow, fill_bytes);
        else pass_cnt++;
        do_dump(-1, 0, 1'b0, t0, f, o);
        total_cnt++;
        if (mem_img[0] !== 32'h800003FC) $display("FAIL ovf_hdr: got %08h required 800003FC", mem_img[0]);
        else pass_cnt++;
        total_cnt++;
        if (mem_img[1] !== 32'h03020100 || mem_img[255] !== 32'hFBFAF9F8)
            $display("FAIL ovf_words: a1=%08h a255=%08h required 03020100/FBFAF9F8", mem_img[1], mem_img[255]);
        else pass_cnt++;
        total_cnt++;
        if (we_count !== 256 || we_last - we_first + 1 !== 256 || !addr_ok || hs_rise !== t0 + 258)
            $display("FAIL ovf_we: count=%0d span=%0d addr_ok=%b hs_rise=%0d required 256/256/1/%0d",
                     we_count, we_last - we_first + 1, addr_ok, hs_rise, t0 + 258);
        else pass_cnt++;
    endtask

    task automatic test_empty();
        int t0; logic [9:0] f; logic o;
        do_reset();
        do_dump(-1, 0, 1'b0, t0, f, o);
        total_cnt++;
        if (we_count !== 1 || mem_img[0] !== 32'h00000000 || hs_rise !== t0 + 3)
            $display("FAIL empty_dump: we=%0d hdr=%08h hs_rise=%0d required 1/00000000/%0d",
                     we_count, mem_img[0], hs_rise, t0 + 3);
        else pass_cnt++;
        do_dump(-1, 0, 1'b0, t0, f, o);
        total_cnt++;
        if (mem_img[0] !== 32'h00010000) $display("FAIL empty_seq: hdr=%08h required 00010000", mem_img[0]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t0; logic [9:0] f; logic o;
        do_reset();
        write_bytes(1, 8'hAA); write_bytes(1, 8'hBB);
        do_dump(-1, 0, 1'b1, t0, f, o);
        total_cnt++;
        if (mem_img[0] !== 32'h00000002 || mem_img[1] !== 32'h0000BBAA)
            $display("FAIL hold_first: hdr=%08h w1=%08h required 00000002/0000BBAA", mem_img[0], mem_img[1]);
        else pass_cnt++;
        mon_clr = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); tick(); mon_clr = 1'b0;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if (we_count !== 0 || fill_bytes !== 10'd5 || handshake_fpga !== 1'b0)
            $display("FAIL hold_no_retrigger: we=%0d fill=%0d hs=%b required 0/5/0", we_count, fill_bytes, handshake_fpga);
        else pass_cnt++;
        dump_req = 1'b0;
        do_dump(6, 0, 1'b0, t0, f, o);
        total_cnt++;
        if (mem_img[0] !== 32'h00010006 || mem_img[1] !== 32'h04030201 || mem_img[2] !== 32'h00000605)
            $display("FAIL hold_second: hdr=%08h w1=%08h w2=%08h required 00010006/04030201/00000605",
                     mem_img[0], mem_img[1], mem_img[2]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int t0; int guard; logic [9:0] f; logic o;
        do_reset();
        do_dump(-1, 0, 1'b0, t0, f, o);
        write_bytes(3, 8'h70);
        dump_req = 1'b1;
        guard = 0;
        while (handshake_fpga !== 1'b1 && guard < 50) begin tick(); guard++; end
        total_cnt++;
        if (handshake_fpga !== 1'b1) $display("FAIL midrst_reach_hs: hs=%b required 1", handshake_fpga);
        else pass_cnt++;
        RESET = 1'b1; dump_req = 1'b0;
        tick();
        total_cnt++;
        if (handshake_fpga !== 1'b0 || fill_bytes !== 10'd0 || ram_we !== 1'b0)
            $display("FAIL midrst_clear: hs=%b fill=%0d we=%b required 0/0/0", handshake_fpga, fill_bytes, ram_we);
        else pass_cnt++;
        RESET = 1'b0;
        tick();
        do_dump(-1, 0, 1'b0, t0, f, o);
        total_cnt++;
        if (mem_img[0] !== 32'h00000000) $display("FAIL midrst_seq: hdr=%08h required 00000000", mem_img[0]);
        else pass_cnt++;
    endtask

    task automatic test_ignored();
        int t0; logic [9:0] f; logic o;
        do_reset();
        write_bytes(40, 0);
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin handshake_pc = ~handshake_pc; tick(); end
        handshake_pc = 1'b0;
        tick(); tick(); tick();
        total_cnt++;
        if (handshake_fpga !== 1'b0 || we_count !== 0 || fill_bytes !== 10'd40 || dump_done !== 1'b0)
            $display("FAIL idle_pc: hs=%b we=%0d fill=%0d done=%b required 0/0/40/0",
                     handshake_fpga, we_count, fill_bytes, dump_done);
        else pass_cnt++;
        do_dump(-1, 8, 1'b0, t0, f, o);
        total_cnt++;
        if (f !== 10'd40 || o !== 1'b0)
            $display("FAIL data_wr_ignored: fill=%0d ovf=%b required 40/0", f, o);
        else pass_cnt++;
        total_cnt++;
        if (we_count !== 11 || mem_img[0] !== 32'h00000028 || mem_img[10] !== 32'h27262524)
            $display("FAIL data_contents: we=%0d hdr=%08h w10=%08h required 11/00000028/27262524",
                     we_count, mem_img[0], mem_img[10]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        test_ignored();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
